// File: rtl/aidc_lite_comp_zrle.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aidc_lite_comp_zrle : zero-run line compressor, 8x64-bit lines -> 32-bit words
// Revision: 1.0
// ----------------------------------------------------------------------------
module aidc_lite_comp_zrle #(
  parameter logic [1:0] PREFIX = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sop_o,
  output logic        eop_o,
  output logic [31:0] data_o,
  output logic [4:0]  len_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [7:0]   fill_q, fill_d;
  logic [2:0]   line_q, line_d;
  logic [4:0]   wcnt_q, wcnt_d;
  logic         sop_pend_q, sop_pend_d;

  logic [3:0]   nz;
  logic [5:0]   tag_bits;
  logic [7:0]   tag_len;
  logic [127:0] code;
  logic [7:0]   clen;
  logic [127:0] shifted;
  logic [7:0]   base;
  logic         push, pop, last_word;

  // Line code built MSB-aligned: optional prefix, tag, then non-zero words.
  always_comb begin
    nz = {|data_i[63:48], |data_i[47:32], |data_i[31:16], |data_i[15:0]};
    tag_bits = 6'b000000;
    tag_len  = 8'd6;
    case (nz)
      4'b0000: begin tag_bits = 6'b000000; tag_len = 8'd6; end
      4'b0001: begin tag_bits = 6'b000001; tag_len = 8'd6; end
      4'b0010: begin tag_bits = 6'b000010; tag_len = 8'd5; end
      4'b0100: begin tag_bits = 6'b000100; tag_len = 8'd5; end
      4'b1000: begin tag_bits = 6'b000110; tag_len = 8'd5; end
      4'b0011: begin tag_bits = 6'b001000; tag_len = 8'd4; end
      4'b0101: begin tag_bits = 6'b001100; tag_len = 8'd4; end
      4'b1001: begin tag_bits = 6'b010000; tag_len = 8'd4; end
      4'b0110: begin tag_bits = 6'b010100; tag_len = 8'd4; end
      4'b1010: begin tag_bits = 6'b011000; tag_len = 8'd4; end
      4'b1100: begin tag_bits = 6'b011100; tag_len = 8'd4; end
      4'b0111: begin tag_bits = 6'b100000; tag_len = 8'd4; end
      4'b1011: begin tag_bits = 6'b100100; tag_len = 8'd4; end
      4'b1101: begin tag_bits = 6'b101000; tag_len = 8'd4; end
      4'b1110: begin tag_bits = 6'b101100; tag_len = 8'd4; end
      default: begin tag_bits = 6'b110000; tag_len = 8'd2; end
    endcase

    code = '0;
    clen = 8'd0;
    if (line_q == 3'd0) begin
      code = {PREFIX, 126'b0};
      clen = 8'd2;
    end
    code = code | ({tag_bits, 122'b0} >> clen);
    clen = clen + tag_len;
    for (int i = 0; i < 4; i++) begin
      if (nz[3-i]) begin
        code = code | ({data_i[16*(3-i) +: 16], 112'b0} >> clen);
        clen = clen + 8'd16;
      end
    end
  end

  assign ready_o   = (state_q != FLUSH) && (fill_q <= 8'd62);
  assign valid_o   = (fill_q >= 8'd32) || ((state_q == FLUSH) && (fill_q != 8'd0));
  assign last_word = valid_o && (state_q == FLUSH) && (fill_q <= 8'd32);
  assign push      = valid_i && ready_o;
  assign pop       = valid_o && ready_i;

  assign data_o = valid_o ? acc_q[127:96] : 32'd0;
  assign sop_o  = valid_o && sop_pend_q;
  assign eop_o  = last_word;
  assign len_o  = last_word ? (wcnt_q + 5'd1) : 5'd0;

  // A popped word frees 32 bits first, so a same-cycle push lands right after what remains.
  always_comb begin
    shifted    = pop ? {acc_q[95:0], 32'b0} : acc_q;
    base       = pop ? ((fill_q > 8'd32) ? (fill_q - 8'd32) : 8'd0) : fill_q;
    acc_d      = push ? (shifted | (code >> base)) : shifted;
    fill_d     = push ? (base + clen) : base;
    line_d     = push ? (line_q + 3'd1) : line_q;
    wcnt_d     = wcnt_q;
    sop_pend_d = sop_pend_q;
    state_d    = state_q;

    if (pop) begin
      sop_pend_d = 1'b0;
      wcnt_d     = last_word ? 5'd0 : (wcnt_q + 5'd1);
    end

    case (state_q)
      IDLE: if (push) begin
        state_d    = ENC;
        sop_pend_d = 1'b1;
      end
      ENC: if (push && (line_q == 3'd7)) state_d = FLUSH;
      FLUSH: if (pop && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      fill_q     <= 8'd0;
      line_q     <= 3'd0;
      wcnt_q     <= 5'd0;
      sop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      line_q     <= line_d;
      wcnt_q     <= wcnt_d;
      sop_pend_q <= sop_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/aidc_lite_comp_zrle.md
AIDC_LITE_COMP_ZRLE -- requirements
Module: AIDC_LITE_COMP_ZRLE

Interface
REQ-001 SHALL have parameter: PREFIX, 2'b10, 2-bit algorithm ID placed in bits [31:30] of the first output word of every block.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: valid_i  input  1  input line valid.
REQ-005 SHALL have ports: ready_o  output  1  input line accepted when valid_i&ready_o.
REQ-006 SHALL have ports: data_i  input  64  line; word0=[63:48] .. word3=[15:0].
REQ-007 SHALL have ports: valid_o  output  1  output word valid.
REQ-008 SHALL have ports: ready_i  input  1  downstream accepts word when valid_o&ready_i.
REQ-009 SHALL have ports: sop_o  output  1  first word of block.
REQ-010 SHALL have ports: eop_o  output  1  last word of block.
REQ-011 SHALL have ports: data_o  output  32  code word, MSB first; 0 when valid_o=0.
REQ-012 SHALL have ports: len_o  output  5  word count of block (2..17), valid only with eop_o; else 0.

Function
REQ-013 SHALL treat a block as exactly 8 consecutive accepted lines; internal line counter 0..7.
REQ-014 SHALL classify each 16-bit word as Z (==0) or N; encode line as tag then N-words in order word0..word3, MSB first.
REQ-015 SHALL use tags (pattern word0..3): ZZZZ 000000; ZZZN 000001; ZZNZ 00001; ZNZZ 00010; NZZZ 00011; ZZNN 0010; ZNZN 0011; NZZN 0100; ZNNZ 0101; NZNZ 0110; NNZZ 0111; ZNNN 1000; NZNN 1001; NNZN 1010; NNNZ 1011; NNNN 11.
REQ-016 SHALL produce code lengths 6, 22, 21, 36, 52, 66 bits for 0, 1(ZZZN), 1(other), 2, 3, 4 N-words respectively.
REQ-017 SHALL pack into a 128-bit MSB-aligned accumulator with 8-bit fill count; new code appended immediately after existing valid bits.
REQ-018 SHALL prepend PREFIX (2 bits) before the code of line 0.
REQ-019 SHALL implement states IDLE (fill=0, no block open), ENC (lines 1..7 pending), FLUSH (all 8 lines accepted, draining).
REQ-020 SHALL transition IDLE->ENC on line-0 accept, ENC->FLUSH on line-7 accept, FLUSH->IDLE when last word handshakes.
REQ-021 SHALL drive ready_o=1 iff state!=FLUSH and fill<=62 (registered fill, no combinational path from valid_i/ready_i).
REQ-022 SHALL drive valid_o=1 iff fill>=32, or state==FLUSH and fill>0; data_o = accumulator[127:96].
REQ-023 SHALL, on word handshake, shift accumulator left 32 and fill-=32 (saturating at 0 for final partial word, pad bits 0).
REQ-024 SHALL handle push and pop in same cycle: new code appended at (fill-32) position, fill = fill-32+len.
REQ-025 SHALL assert sop_o on the first word of each block, eop_o on the word after which fill=0 in FLUSH; word count = ceil((2+sum len)/32).
REQ-026 SHALL hold data_o/sop_o/eop_o/len_o stable while valid_o=1 and ready_i=0.
REQ-027 SHALL allow line 0 of the next block only after return to IDLE (no overlap of blocks).
REQ-028 SHALL never overflow: max fill after push = 62+66 = 128.

Reset
REQ-029 SHALL on rst_n=0 asynchronously clear accumulator, fill, line counter, word counter, state=IDLE; outputs valid_o=0, sop_o=0, eop_o=0, data_o=0, len_o=0, ready_o=1 after release.
REQ-030 SHALL discard any partial block on mid-operation reset; next accepted line is line 0.

Verification
REQ-031 All-zero block, PREFIX=2'b10 -> 50 bits, 2 words: 0x80000000 (sop), 0x00000000 (eop, len_o=2).
REQ-032 Line0=64'h0000_0000_0000_ABCD, lines1..7=0 -> 66 bits, 3 words: 0x81ABCD00 (sop), 0x00000000, 0x00000000 (eop, len_o=3).
REQ-033 8 lines of 64'h0001_0002_0003_0004 -> 530 bits, 17 words, first 0xB0001000, eop on 17th, len_o=17; ready_o drops whenever fill>62.
REQ-034 Case 2 with ready_i=0 for 5 cycles mid-block -> outputs held stable, no words lost or duplicated, ready_o=0 once fill>62.
REQ-035 Reset asserted after line 3 accepted -> valid_o=0 immediately; new all-zero block afterwards yields exactly REQ-031 output.
REQ-036 Two back-to-back blocks with valid_i held high and ready_i=1 -> second block's line 0 stalls until eop handshake; sop_o reasserts on its first word.
